// File: rtl/sqrt_req_arbiter.sv
// Round-robin sharing of one fixed-latency Q8.24 sqrt pipeline among NUM_REQ requesters.
// Build option SQRT_ARB_NEG_CHECK_EN: negative operands issue as 0 and are flagged on rsp_neg.
module sqrt_req_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int TAG_W    = 2,
    parameter int SQRT_LAT = 53
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [32*NUM_REQ-1:0]  req_data,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [31:0]            sq_a,
    output logic                   sq_new_data,
    input  logic [31:0]            sq_r,
    input  logic                   sq_output_valid,
    output logic [NUM_REQ-1:0]     rsp_valid,
    output logic [31:0]            rsp_data,
`ifdef SQRT_ARB_NEG_CHECK_EN
    output logic                   rsp_neg,
`endif
    output logic                   busy,
    output logic                   err_spurious
);

    localparam int CNT_W = $clog2(SQRT_LAT + 3) + 1;

    function automatic logic [TAG_W-1:0] f_wrap(input int v);
        return TAG_W'(v % NUM_REQ);
    endfunction

    logic [TAG_W-1:0]    r_rr_ptr;
    logic [31:0]         r_sq_a;
    logic                r_sq_new;
    logic [TAG_W-1:0]    r_sq_tag;
    logic [SQRT_LAT-1:0] r_tl_vld;
    logic [TAG_W-1:0]    r_tl_tag [SQRT_LAT];
    logic [NUM_REQ-1:0]  r_rsp_valid;
    logic [31:0]         r_rsp_data;
    logic [CNT_W-1:0]    r_inflight;
    logic                r_err;

    logic                w_found;
    logic                w_hs;
    logic [TAG_W-1:0]    w_gnt_idx;
    logic [NUM_REQ-1:0]  w_gnt;
    logic [31:0]         w_gnt_data;
    logic [31:0]         w_issue_a;
    logic                w_tail_vld;
    logic [TAG_W-1:0]    w_tail_tag;
    logic                w_route;
    logic [31:0]         w_rsp_d;

`ifdef SQRT_ARB_NEG_CHECK_EN
    logic                r_sq_neg;
    logic [SQRT_LAT-1:0] r_tl_neg;
    logic                r_rsp_neg;
    logic                w_gnt_neg;
    logic                w_tail_neg;
`endif

    // First valid requester at or after r_rr_ptr, wrapping
    always_comb begin
        w_found   = 1'b0;
        w_gnt_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_found && req_valid[f_wrap(int'(r_rr_ptr) + k)]) begin
                w_found   = 1'b1;
                w_gnt_idx = f_wrap(int'(r_rr_ptr) + k);
            end
        end
    end

    assign w_hs       = w_found & rst;
    assign w_gnt      = w_hs ? (NUM_REQ'(1) << w_gnt_idx) : '0;
    assign w_gnt_data = req_data[32*int'(w_gnt_idx) +: 32];
    assign w_tail_vld = r_tl_vld[SQRT_LAT-1];
    assign w_tail_tag = r_tl_tag[SQRT_LAT-1];
    assign w_route    = sq_output_valid & w_tail_vld;

`ifdef SQRT_ARB_NEG_CHECK_EN
    assign w_gnt_neg  = w_gnt_data[31];
    assign w_tail_neg = r_tl_neg[SQRT_LAT-1];
    assign w_issue_a  = w_gnt_neg ? 32'd0 : w_gnt_data;
    assign w_rsp_d    = w_tail_neg ? 32'd0 : sq_r;
    assign rsp_neg    = r_rsp_neg;
`else
    assign w_issue_a  = w_gnt_data;
    assign w_rsp_d    = sq_r;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rr_ptr    <= '0;
            r_sq_a      <= '0;
            r_sq_new    <= 1'b0;
            r_sq_tag    <= '0;
            r_tl_vld    <= '0;
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
            r_inflight  <= '0;
            r_err       <= 1'b0;
            for (int i = 0; i < SQRT_LAT; i++) begin
                r_tl_tag[i] <= '0;
            end
`ifdef SQRT_ARB_NEG_CHECK_EN
            r_sq_neg    <= 1'b0;
            r_tl_neg    <= '0;
            r_rsp_neg   <= 1'b0;
`endif
        end else begin
            r_sq_new <= w_hs;
            if (w_hs) begin
                r_sq_a   <= w_issue_a;
                r_sq_tag <= w_gnt_idx;
                r_rr_ptr <= f_wrap(int'(w_gnt_idx) + 1);
            end

            // Tail entry lines up with the pipeline output SQRT_LAT cycles after issue
            r_tl_vld    <= {r_tl_vld[SQRT_LAT-2:0], r_sq_new};
            r_tl_tag[0] <= r_sq_tag;
            for (int i = 1; i < SQRT_LAT; i++) begin
                r_tl_tag[i] <= r_tl_tag[i-1];
            end

            if (w_route) begin
                r_rsp_valid <= NUM_REQ'(1) << w_tail_tag;
                r_rsp_data  <= w_rsp_d;
            end else begin
                r_rsp_valid <= '0;
            end

            if (sq_output_valid != w_tail_vld) begin
                r_err <= 1'b1;
            end

            if (w_hs && !w_tail_vld) begin
                r_inflight <= r_inflight + 1'b1;
            end else if (!w_hs && w_tail_vld) begin
                r_inflight <= r_inflight - 1'b1;
            end

`ifdef SQRT_ARB_NEG_CHECK_EN
            if (w_hs) begin
                r_sq_neg <= w_gnt_neg;
            end
            r_tl_neg  <= {r_tl_neg[SQRT_LAT-2:0], r_sq_neg};
            r_rsp_neg <= w_route & w_tail_neg;
`endif
        end
    end

    assign req_ready    = w_gnt;
    assign sq_a         = r_sq_a;
    assign sq_new_data  = r_sq_new;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_data     = r_rsp_data;
    assign busy         = (r_inflight != '0);
    assign err_spurious = r_err;

endmodule
